rggen_apb_initiator: RTL
========================

Name: rggen_apb_initiator

Overview:
- APB initiator (master) that turns a simple valid/ready command port into APB transactions on a `rggen_apb_if.master` port.
- Used by test harnesses and on-chip sequencers to drive generated register blocks that expose `rggen_apb_if.slave`.
- Runs one transaction at a time.
- Returns read data and a completion status through a valid/ready response port.
- Guards against a hung slave with a PREADY timeout.

Parameters:
- ADDRESS_WIDTH, 8, width of PADDR and of the request address.
- BUS_WIDTH, 32, width of PWDATA/PRDATA; a power of two, at least 8.
- TIMEOUT_CYCLES, 256, number of ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high
- i_request_valid  input  1  command valid
- o_request_ready  output  1  command accepted when valid and ready are both high
- i_request_write  input  1  1 = write, 0 = read
- i_request_address  input  ADDRESS_WIDTH  byte address
- i_request_write_data  input  BUS_WIDTH  write data
- i_request_strobe  input  BUS_WIDTH/8  byte strobes (writes only)
- o_response_valid  output  1  response valid
- i_response_ready  input  1  response accepted
- o_response_status  output  2  rggen_apb_status_e: OKAY=0, SLVERR=1, TIMEOUT=2
- o_response_read_data  output  BUS_WIDTH  read data (0 for writes and timeouts)
- apb_if  rggen_apb_if.master  -  drives psel, penable, paddr, pwrite, pwdata, pstrb, pprot; samples pready, prdata, pslverr

Behaviour:
- States: IDLE, SETUP, ACCESS, RESPONSE. Reset value is IDLE.
- Reset values:
  - psel = 0, penable = 0, pwrite = 0; paddr, pwdata and pstrb = 0; pprot = 3'b000.
  - o_request_ready = 0 during reset, then 1 in IDLE.
  - o_response_valid = 0, o_response_status = OKAY, o_response_read_data = 0.
- o_request_ready is combinational: high only in IDLE.
- IDLE -> SETUP on a request handshake.
  - Register write flag, address, data and strobe into the APB outputs on that edge.
  - Clear the low log2(BUS_WIDTH/8) address bits.
  - Force pstrb to 0 for reads.
- SETUP: psel = 1, penable = 0, held for exactly one cycle, then ACCESS.
- ACCESS: psel = 1, penable = 1; all APB outputs stay stable.
  - On the first cycle with pready = 1:
    - capture prdata for reads (0 for writes);
    - set status = SLVERR if pslverr = 1, else OKAY;
    - drop psel/penable at the next edge;
    - go to RESPONSE.
- Timeout (TIMEOUT_CYCLES > 0):
  - The wait counter clears on SETUP -> ACCESS.
  - It increments on each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYCLES while pready is still 0: abort (psel = 0, penable = 0), status = TIMEOUT, read data = 0, go to RESPONSE.
  - pready = 1 on the same cycle as the limit wins: normal completion.
  - Counter width: $clog2(TIMEOUT_CYCLES+1), saturating.
- RESPONSE: o_response_valid = 1; status and data held stable until i_response_ready.
  - On the handshake: go to IDLE and drop o_response_valid at the next edge.
- Minimum latency:
  - Request handshake at cycle 0, SETUP at cycle 1, ACCESS at cycle 2 (zero-wait slave), o_response_valid at cycle 3.
  - Back-to-back requests: next accepted at cycle 4 if the response is taken at cycle 3, giving one transaction per 4 cycles.
- A request presented while busy is not accepted; o_request_ready = 0 and the request is held by the requester.
- i_rst asserted mid-operation: the next edge forces reset values. The APB transfer is abandoned and no response is produced.
- PSLVERR is sampled only when pready = 1 in ACCESS and ignored otherwise.

Decomposition:
- rggen_rtl_pkg gains:
  - typedef enum logic [1:0] rggen_apb_status_e {OKAY, SLVERR, TIMEOUT};
  - typedef enum logic [1:0] rggen_apb_initiator_state_e {IDLE, SETUP, ACCESS, RESPONSE}.
- One sub-module, rggen_wait_timer.
  - Ports: i_clk, i_rst, i_clear, i_enable, o_expired; parameter CYCLES.
  - It is tied off when CYCLES = 0 (o_expired = 0).
  - Reusable by other bus initiators.

Test Plan:
1. Write addr 8'h04, data 32'hA5A5_0F0F, strobe 4'hF, zero-wait slave -> psel rises cycle 1, penable cycle 2, response cycle 3 with status OKAY, read_data 0; slave register holds 32'hA5A5_0F0F.
2. Read addr 8'h06 with slave pready delayed 3 cycles, prdata 32'h0000_0F0F -> paddr = 8'h04, pstrb = 0, penable held 4 cycles, response OKAY with read_data 32'h0000_0F0F.
3. Slave returns pslverr = 1 with pready -> status SLVERR; psel drops next edge.
4. TIMEOUT_CYCLES = 4, pready stuck 0 -> psel/penable drop after 4 ACCESS wait cycles, status TIMEOUT, read_data 0. Same test with pready = 1 on the 4th cycle -> status OKAY.
5. Hold i_response_ready = 0 for 5 cycles with a second request pending -> response stable, o_request_ready = 0 throughout; second request accepted one cycle after the response handshake.
6. Assert i_rst for 1 cycle during ACCESS -> next cycle psel = 0, penable = 0, o_response_valid = 0, o_request_ready = 1 after reset release; no response is ever emitted.

Source files
------------

// File: rtl/rggen_apb_initiator_pkg.sv
// rggen_rtl_pkg: shared types for the APB initiator and its helpers.
//   rggen_apb_status_e          - completion status reported on the response port
//   rggen_apb_initiator_state_e - transaction sequencer states
//   RGGEN_APB_PPROT_DEFAULT     - protection attribute driven on every transfer
//   rggen_byte_lanes_log2()     - number of address bits covered by one bus word
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        OKAY    = 2'd0,
        SLVERR  = 2'd1,
        TIMEOUT = 2'd2
    } rggen_apb_status_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESPONSE
    } rggen_apb_initiator_state_e;

    localparam logic [2:0] RGGEN_APB_PPROT_DEFAULT = 3'b000;

    function automatic int unsigned rggen_byte_lanes_log2(input int unsigned bus_width);
        return $clog2(bus_width / 8);
    endfunction

endpackage

// File: rtl/rggen_apb_initiator_if.sv
// rggen_apb_if: APB3/APB4 bus bundle.
//   master modport - drives psel, penable, paddr, pprot, pwrite, pstrb, pwdata;
//                    samples pready, prdata, pslverr
//   slave modport  - the mirror image, used by register blocks
interface rggen_apb_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
);

    logic                       psel;
    logic                       penable;
    logic [ADDRESS_WIDTH-1:0]   paddr;
    logic [2:0]                 pprot;
    logic                       pwrite;
    logic [BUS_WIDTH/8-1:0]     pstrb;
    logic [BUS_WIDTH-1:0]       pwdata;
    logic                       pready;
    logic [BUS_WIDTH-1:0]       prdata;
    logic                       pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/rggen_apb_initiator_wait_timer.sv
// rggen_wait_timer: saturating wait-cycle counter for bus initiators.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_clear      - restart the count (asserted the cycle before waiting begins)
//   i_enable     - one wait cycle elapses in this cycle
//   o_expired    - this enabled cycle is the CYCLES-th consecutive wait
// CYCLES = 0 disables the timer entirely (o_expired stays low).
module rggen_wait_timer #(
    parameter int unsigned CYCLES = 256
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    if (CYCLES == 0) begin : g_disabled
        logic unused_inputs;
        assign unused_inputs = &{1'b0, i_clk, i_rst, i_clear, i_enable};
        assign o_expired     = 1'b0;
    end else begin : g_timer
        localparam int unsigned WIDTH = $clog2(CYCLES + 1);
        localparam logic [WIDTH-1:0] LIMIT = WIDTH'(CYCLES);

        logic [WIDTH-1:0] count_q;
        logic [WIDTH-1:0] count_d;

        always_comb begin
            count_d = count_q;
            if (i_clear) begin
                count_d = '0;
            end else if (i_enable && (count_q != LIMIT)) begin
                count_d = count_q + 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        // Flag expiry combinationally on the wait cycle that brings the count
        // to the limit so the caller can abort on that same edge.
        assign o_expired = i_enable && !i_clear && (count_q >= (LIMIT - 1'b1));
    end

endmodule

// File: rtl/rggen_apb_initiator.sv
// rggen_apb_initiator: turns a valid/ready command port into single APB
// transfers and returns status/read data on a valid/ready response port.
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_request_*            - command: write flag, byte address, data, strobes
//   o_request_ready        - high only while idle (and not in reset)
//   o_response_valid       - response pending; held until i_response_ready
//   o_response_status      - OKAY / SLVERR / TIMEOUT
//   o_response_read_data   - read data (0 for writes and timeouts)
//   apb_if                 - APB master port
module rggen_apb_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
)(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_request_valid,
    output logic                        o_request_ready,
    input  logic                        i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]    i_request_address,
    input  logic [BUS_WIDTH-1:0]        i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]      i_request_strobe,
    output logic                        o_response_valid,
    input  logic                        i_response_ready,
    output rggen_apb_status_e           o_response_status,
    output logic [BUS_WIDTH-1:0]        o_response_read_data,
    rggen_apb_if.master                 apb_if
);

    localparam int unsigned ADDR_LSB = rggen_byte_lanes_log2(BUS_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = {ADDRESS_WIDTH{1'b1}} << ADDR_LSB;

    rggen_apb_initiator_state_e state_q, state_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]       pwdata_q, pwdata_d;
    logic [BUS_WIDTH/8-1:0]     pstrb_q, pstrb_d;
    logic                       response_valid_q, response_valid_d;
    rggen_apb_status_e          response_status_q, response_status_d;
    logic [BUS_WIDTH-1:0]       response_read_data_q, response_read_data_d;
    logic                       timer_expired;

    assign o_request_ready      = (state_q == IDLE) && !i_rst;
    assign o_response_valid     = response_valid_q;
    assign o_response_status    = response_status_q;
    assign o_response_read_data = response_read_data_q;

    assign apb_if.psel    = psel_q;
    assign apb_if.penable = penable_q;
    assign apb_if.pwrite  = pwrite_q;
    assign apb_if.paddr   = paddr_q;
    assign apb_if.pwdata  = pwdata_q;
    assign apb_if.pstrb   = pstrb_q;
    assign apb_if.pprot   = RGGEN_APB_PPROT_DEFAULT;

    rggen_wait_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (state_q == SETUP),
        .i_enable  ((state_q == ACCESS) && !apb_if.pready),
        .o_expired (timer_expired)
    );

    always_comb begin
        state_d              = state_q;
        psel_d               = psel_q;
        penable_d            = penable_q;
        pwrite_d             = pwrite_q;
        paddr_d              = paddr_q;
        pwdata_d             = pwdata_q;
        pstrb_d              = pstrb_q;
        response_valid_d     = response_valid_q;
        response_status_d    = response_status_q;
        response_read_data_d = response_read_data_q;

        case (state_q)
            IDLE: begin
                if (i_request_valid && o_request_ready) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = i_request_write;
                    paddr_d  = i_request_address & ADDRESS_MASK;
                    pwdata_d = i_request_write_data;
                    pstrb_d  = i_request_write ? i_request_strobe : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready takes priority over an expiring timer on the same cycle.
                if (apb_if.pready) begin
                    state_d              = RESPONSE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    response_valid_d     = 1'b1;
                    response_status_d    = apb_if.pslverr ? SLVERR : OKAY;
                    response_read_data_d = pwrite_q ? '0 : apb_if.prdata;
                end else if (timer_expired) begin
                    state_d              = RESPONSE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    response_valid_d     = 1'b1;
                    response_status_d    = TIMEOUT;
                    response_read_data_d = '0;
                end
            end
            RESPONSE: begin
                if (i_response_ready) begin
                    state_d          = IDLE;
                    response_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q              <= IDLE;
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            pwrite_q             <= 1'b0;
            paddr_q              <= '0;
            pwdata_q             <= '0;
            pstrb_q              <= '0;
            response_valid_q     <= 1'b0;
            response_status_q    <= OKAY;
            response_read_data_q <= '0;
        end else begin
            state_q              <= state_d;
            psel_q               <= psel_d;
            penable_q            <= penable_d;
            pwrite_q             <= pwrite_d;
            paddr_q              <= paddr_d;
            pwdata_q             <= pwdata_d;
            pstrb_q              <= pstrb_d;
            response_valid_q     <= response_valid_d;
            response_status_q    <= response_status_d;
            response_read_data_q <= response_read_data_d;
        end
    end

endmodule
